// File: rtl/adpll_pkg.sv
// Shared ADPLL types and constants: phase-detector FSM states and the phase-error width
// used by both the detector and the downstream loop filter.
package adpll_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    REF_LEAD = 2'd1,
    FB_LEAD  = 2'd2
  } pd_state_t;

  localparam int PD_ERR_W = 8;

  // Largest positive value of a signed w-bit phase error.
  function automatic int err_max(input int w);
    return (2 ** (w - 1)) - 1;
  endfunction

  localparam int ERR_MAX = (2 ** (PD_ERR_W - 1)) - 1;

endpackage

// File: rtl/adpll_phase_detector_if.sv
// Phase-detector signal bundle: async clock inputs in, loop-filter facing results out.
interface adpll_phase_detector_if
  import adpll_pkg::*;
#(
  parameter int ERR_W = PD_ERR_W
);
  logic             ref_in;
  logic             fb_in;
  logic             up;
  logic             dn;
  logic [ERR_W-1:0] phase_err;      // two's complement, +ve = ref led
  logic             phase_err_vld;
  logic             cycle_slip;
  logic             lock;

  modport master (
    output ref_in, fb_in,
    input  up, dn, phase_err, phase_err_vld, cycle_slip, lock
  );

  modport slave (
    input  ref_in, fb_in,
    output up, dn, phase_err, phase_err_vld, cycle_slip, lock
  );
endinterface

// File: rtl/adpll_sync_edge.sv
// Multi-flop synchroniser for an asynchronous clock-like input, followed by a rising-edge
// detector producing a one-cycle pulse in the clk domain.
module adpll_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic i_async,
  output logic o_rise
);
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;

  // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_rise = r_sync[SYNC_STAGES-1] & ~r_prev;
endmodule

// File: rtl/adpll_phase_detector.sv
// Counter-based phase-frequency detector for the ADPLL (ref vs divided feedback).
// Optional lock detector enabled by defining ADPLL_PD_LOCK_DET_EN.
module adpll_phase_detector
  import adpll_pkg::*;
#(
  parameter int ERR_W       = PD_ERR_W,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 2,
  parameter int LOCK_COUNT  = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  adpll_phase_detector_if.slave  pd
);
  localparam logic [ERR_W-1:0] CNT_MAX = ERR_W'(err_max(ERR_W));
  localparam logic [ERR_W-1:0] CNT_ONE = ERR_W'(1);

  logic             w_ref_rise, w_fb_rise;
  pd_state_t        r_state, w_state_nxt;
  logic [ERR_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [ERR_W-1:0] r_phase_err, w_phase_err_nxt;
  logic             r_vld, w_vld_nxt;
  logic             r_slip, w_slip_nxt;
  logic             r_up, r_dn;

  adpll_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_ref_sync (
    .clk(clk), .reset(reset), .i_async(pd.ref_in), .o_rise(w_ref_rise)
  );
  adpll_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_fb_sync (
    .clk(clk), .reset(reset), .i_async(pd.fb_in), .o_rise(w_fb_rise)
  );

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CNT_ONE;

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_phase_err_nxt = r_phase_err;
    w_vld_nxt       = 1'b0;
    w_slip_nxt      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_ref_rise && w_fb_rise) begin
          w_phase_err_nxt = '0;
          w_vld_nxt       = 1'b1;
        end else if (w_ref_rise) begin
          w_state_nxt = REF_LEAD;
          w_cnt_nxt   = CNT_ONE;
        end else if (w_fb_rise) begin
          w_state_nxt = FB_LEAD;
          w_cnt_nxt   = CNT_ONE;
        end
      end
      REF_LEAD: begin
        if (w_fb_rise) begin
          w_phase_err_nxt = r_cnt;
          w_vld_nxt       = 1'b1;
          // A fresh ref edge on the closing cycle re-opens immediately.
          w_state_nxt     = w_ref_rise ? REF_LEAD : IDLE;
          w_cnt_nxt       = w_ref_rise ? CNT_ONE : '0;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_slip_nxt = w_ref_rise;
        end
      end
      FB_LEAD: begin
        if (w_ref_rise) begin
          w_phase_err_nxt = -r_cnt;
          w_vld_nxt       = 1'b1;
          w_state_nxt     = w_fb_rise ? FB_LEAD : IDLE;
          w_cnt_nxt       = w_fb_rise ? CNT_ONE : '0;
        end else begin
          w_cnt_nxt  = w_cnt_inc;
          w_slip_nxt = w_fb_rise;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_phase_err <= '0;
      r_vld       <= 1'b0;
      r_slip      <= 1'b0;
      r_up        <= 1'b0;
      r_dn        <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_phase_err <= w_phase_err_nxt;
      r_vld       <= w_vld_nxt;
      r_slip      <= w_slip_nxt;
      r_up        <= (w_state_nxt == REF_LEAD);
      r_dn        <= (w_state_nxt == FB_LEAD);
    end
  end

  assign pd.up            = r_up;
  assign pd.dn            = r_dn;
  assign pd.phase_err     = r_phase_err;
  assign pd.phase_err_vld = r_vld;
  assign pd.cycle_slip    = r_slip;

`ifdef ADPLL_PD_LOCK_DET_EN
  localparam int LC_W = $clog2(LOCK_COUNT + 1);

  logic [LC_W-1:0]  r_lock_cnt;
  logic [ERR_W-1:0] w_err_mag;

  assign w_err_mag = r_phase_err[ERR_W-1] ? -r_phase_err : r_phase_err;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock_cnt <= '0;
    end else if (r_slip || (r_vld && (w_err_mag > ERR_W'(LOCK_TOL)))) begin
      r_lock_cnt <= '0;
    end else if (r_vld && (r_lock_cnt != LC_W'(LOCK_COUNT))) begin
      r_lock_cnt <= r_lock_cnt + LC_W'(1);
    end
  end

  assign pd.lock = (r_lock_cnt == LC_W'(LOCK_COUNT));
`else
  assign pd.lock = 1'b0;
`endif
endmodule
